bip_run_controller: RTL
=======================

// Module: bip_run_controller
// PURPOSE
//  Run/step sequencer for the BIP core. Takes command bytes from the UART receiver and
//  drives the core's active-low reset and clock enable. On halt (done), timeout or after
//  one step, it sends a 5-byte status report (status, cycle count, ACC) to the UART
//  transmitter. Sits between the UART pair and the BIP top.
// PARAMETERS
//  TIMEOUT    16'd2047  enabled-cycle limit before a forced stop (1..65535)
//  CMD_RUN    8'h52     'R': run until done/timeout
//  CMD_STEP   8'h53     'S': run exactly one enabled cycle
//  CMD_CLEAR  8'h43     'C': abandon HOLD, re-reset core
// PORTS
//  clk          in   1   system clock; all logic on posedge
//  rst          in   1   reset, synchronous, active-low
//  i_rx_data    in   8   received command byte
//  i_rx_valid   in   1   1-cycle pulse, i_rx_data valid
//  i_bip_done   in   1   core halt flag (BIP o_done)
//  i_acc        in   16  core accumulator value
//  i_tx_done    in   1   1-cycle pulse, transmitter finished current byte
//  o_bip_rst_n  out  1   core reset, active-low; 0 holds core at PC=0
//  o_bip_enable out  1   core clock enable
//  o_tx_start   out  1   1-cycle pulse, send o_tx_data
//  o_tx_data    out  8   report byte; held stable until i_tx_done
//  o_busy       out  1   1 in every state except IDLE and HOLD
// BEHAVIOUR
//  Reset (rst=0 at posedge): state=IDLE, count=0, snapshot regs=0. Outputs: o_bip_rst_n=0,
//   o_bip_enable=0, o_tx_start=0, o_tx_data=0, o_busy=0. An in-flight report is dropped.
//  All outputs are registered.
//  States: IDLE, RUN, STEP, HOLD, SEND, WAIT.
//  IDLE: o_bip_rst_n=0. On rx_valid:
//   - CMD_RUN  -> RUN, count=0.
//   - CMD_STEP -> STEP, count=0.
//   - Any other byte is ignored.
//  RUN/STEP: o_bip_rst_n=1, o_bip_enable=1.
//   - count increments by 1 on every posedge with enable=1 (16-bit).
//   - STEP lasts exactly one enabled cycle.
//  Stop condition, evaluated at the posedge closing an enabled cycle:
//   done = i_bip_done; timeout = (count+1 == TIMEOUT).
//   - RUN stops on done or timeout; STEP stops always.
//   - On stop: enable drops in the same edge; snapshot acc=i_acc, cnt=count+1, flags.
//   - Then -> SEND.
//  Status byte = {4'hA, 1'b0, timeout, done, step}; if done and timeout coincide, both set.
//  Report order: status, cnt[15:8], cnt[7:0], acc[15:8], acc[7:0].
//  SEND: o_tx_start=1 for one cycle with o_tx_data=byte[idx], then -> WAIT.
//  WAIT: hold o_tx_data until i_tx_done.
//   - idx<4: idx++, -> SEND.
//   - idx==4, (done|timeout): -> IDLE, reasserting o_bip_rst_n=0.
//   - idx==4, otherwise (step only): -> HOLD.
//  HOLD: o_bip_rst_n=1, enable=0; core state and count are kept. On rx_valid:
//   - CMD_STEP  -> STEP (count continues).
//   - CMD_RUN   -> RUN (count continues).
//   - CMD_CLEAR -> IDLE.
//   - Any other byte is ignored.
//  rx_valid in RUN/STEP/SEND/WAIT is dropped; no queuing. i_tx_done outside WAIT is ignored.
//  i_acc/i_bip_done are sampled only at a stop edge. Back-to-back report bytes cost at
//  least 2 cycles each.
// TESTING
//  1 Reset: rst=0 for 2 cycles, any inputs -> all outputs 0, o_busy=0.
//  2 Run: 'R'; done=1 on 10th enabled cycle, acc=16'h1234 -> enable high exactly 10 cycles;
//    report A2,00,0A,12,34; then o_bip_rst_n=0 and o_busy=0.
//  3 Step: 'S', acc=5 -> 1 enable cycle, report A1,00,01,00,05, HOLD with rst_n=1;
//    a second 'S' -> report A1,00,02,..; then 'C' -> IDLE, rst_n=0.
//  4 Timeout: TIMEOUT=20, done never set, 'R' -> 20 enabled cycles; report A4,00,14,..
//  5 Flow: i_tx_done delayed 50 cycles per byte; 'R' bytes injected during SEND/WAIT ->
//    o_tx_data stable, exactly 5 start pulses, injected commands have no effect.
//  6 Reset mid-RUN, and again mid-WAIT -> next edge returns all outputs to reset values;
//    no further o_tx_start pulses.

Source files
------------

// File: rtl/bip_run_controller.sv
// Run/step sequencer for the BIP core: decodes UART command bytes, gates the core's
// reset and clock enable, and streams a 5-byte status report back over the UART.
module bip_run_controller #(
  parameter logic [15:0] TIMEOUT   = 16'd2047,
  parameter logic [7:0]  CMD_RUN   = 8'h52,
  parameter logic [7:0]  CMD_STEP  = 8'h53,
  parameter logic [7:0]  CMD_CLEAR = 8'h43
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_bip_done,
  input  logic [15:0] i_acc,
  input  logic        i_tx_done,
  output logic        o_bip_rst_n,
  output logic        o_bip_enable,
  output logic        o_tx_start,
  output logic [7:0]  o_tx_data,
  output logic        o_busy
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_HOLD, S_SEND, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] acc_snap_q, acc_snap_d;
  logic [15:0] cnt_snap_q, cnt_snap_d;
  logic        done_flag_q, done_flag_d;
  logic        timeout_flag_q, timeout_flag_d;
  logic        step_flag_q, step_flag_d;
  logic [2:0]  idx_q, idx_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        bip_rst_n_q, bip_rst_n_d;
  logic        bip_enable_q, bip_enable_d;
  logic        busy_q, busy_d;
  logic        hit_timeout;
  logic [7:0]  status_next;

  function automatic logic [7:0] report_byte(input logic [2:0]  idx,
                                             input logic [7:0]  status,
                                             input logic [15:0] cnt,
                                             input logic [15:0] acc);
    case (idx)
      3'd0:    report_byte = status;
      3'd1:    report_byte = cnt[15:8];
      3'd2:    report_byte = cnt[7:0];
      3'd3:    report_byte = acc[15:8];
      default: report_byte = acc[7:0];
    endcase
  endfunction

  always_comb begin
    // NOTE: every *_d starts from its *_q (or a fixed value) so no branch infers a latch.
    state_d        = state_q;
    count_d        = count_q;
    acc_snap_d     = acc_snap_q;
    cnt_snap_d     = cnt_snap_q;
    done_flag_d    = done_flag_q;
    timeout_flag_d = timeout_flag_q;
    step_flag_d    = step_flag_q;
    idx_d          = idx_q;
    tx_start_d     = 1'b0;
    tx_data_d      = tx_data_q;
    hit_timeout    = (count_q + 16'd1 == TIMEOUT);

    case (state_q)
      S_IDLE: begin
        if (i_rx_valid && i_rx_data == CMD_RUN) begin
          state_d = S_RUN;
          count_d = 16'd0;
        end else if (i_rx_valid && i_rx_data == CMD_STEP) begin
          state_d = S_STEP;
          count_d = 16'd0;
        end
      end
      S_RUN, S_STEP: begin
        count_d = count_q + 16'd1;
        if (state_q == S_STEP || i_bip_done || hit_timeout) begin
          state_d        = S_SEND;
          acc_snap_d     = i_acc;
          cnt_snap_d     = count_q + 16'd1;
          done_flag_d    = i_bip_done;
          timeout_flag_d = hit_timeout;
          step_flag_d    = (state_q == S_STEP);
          idx_d          = 3'd0;
        end
      end
      S_SEND: state_d = S_WAIT;
      S_WAIT: begin
        if (i_tx_done) begin
          if (idx_q != 3'd4) begin
            idx_d   = idx_q + 3'd1;
            state_d = S_SEND;
          end else if (done_flag_q || timeout_flag_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_STEP)       state_d = S_STEP;
          else if (i_rx_data == CMD_RUN)   state_d = S_RUN;
          else if (i_rx_data == CMD_CLEAR) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    status_next = {4'hA, 1'b0, timeout_flag_d, done_flag_d, step_flag_d};
    if (state_d == S_SEND) begin
      tx_start_d = 1'b1;
      tx_data_d  = report_byte(idx_d, status_next, cnt_snap_d, acc_snap_d);
    end
    bip_rst_n_d  = (state_d != S_IDLE);
    bip_enable_d = (state_d == S_RUN) || (state_d == S_STEP);
    busy_d       = (state_d != S_IDLE) && (state_d != S_HOLD);
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge; snapshot registers are cleared with the rest.
    if (!rst) begin
      state_q        <= S_IDLE;
      count_q        <= 16'd0;
      acc_snap_q     <= 16'd0;
      cnt_snap_q     <= 16'd0;
      done_flag_q    <= 1'b0;
      timeout_flag_q <= 1'b0;
      step_flag_q    <= 1'b0;
      idx_q          <= 3'd0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= 8'd0;
      bip_rst_n_q    <= 1'b0;
      bip_enable_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      acc_snap_q     <= acc_snap_d;
      cnt_snap_q     <= cnt_snap_d;
      done_flag_q    <= done_flag_d;
      timeout_flag_q <= timeout_flag_d;
      step_flag_q    <= step_flag_d;
      idx_q          <= idx_d;
      tx_start_q     <= tx_start_d;
      tx_data_q      <= tx_data_d;
      bip_rst_n_q    <= bip_rst_n_d;
      bip_enable_q   <= bip_enable_d;
      busy_q         <= busy_d;
    end
  end

  assign o_bip_rst_n  = bip_rst_n_q;
  assign o_bip_enable = bip_enable_q;
  assign o_tx_start   = tx_start_q;
  assign o_tx_data    = tx_data_q;
  assign o_busy       = busy_q;

endmodule
